// File: rtl/snn_frame_ctrl.sv
// Frame sequencer for the SNN core: loads one UART frame into the input RAM,
// runs inference and returns the classified digit over the UART transmitter.
module snn_frame_ctrl #(
    parameter int NUM_BYTES      = 98,
    parameter int ADDR_WIDTH     = 7,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [7:0]            ram_wdata,
    output logic                  nn_start,
    input  logic                  nn_done,
    input  logic [3:0]            nn_digit,
    input  logic                  tx_rdy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [3:0]            result,
    output logic                  busy,
    output logic [1:0]            err
);

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        SEND    = 3'd3,
        TX_WAIT = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(NUM_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit                    TIMEOUT_EN   = (TIMEOUT_CYCLES > 0);

    state_t                  state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]   byte_cnt_r, byte_cnt_nxt_s;
    logic [CNT_WIDTH-1:0]    idle_cnt_r, idle_cnt_nxt_s;

    logic                    ram_we_r, ram_we_nxt_s;
    logic [ADDR_WIDTH-1:0]   ram_waddr_r, ram_waddr_nxt_s;
    logic [7:0]              ram_wdata_r, ram_wdata_nxt_s;
    logic                    nn_start_r, nn_start_nxt_s;
    logic                    tx_start_r, tx_start_nxt_s;
    logic [7:0]              tx_data_r, tx_data_nxt_s;
    logic [3:0]              result_r, result_nxt_s;
    logic                    busy_r, busy_nxt_s;
    logic [1:0]              err_r, err_nxt_s;

    logic                    timeout_s;
    logic                    overrun_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s;
    logic                    frame_done_s;
    logic                    tx_done_s;

    // A timeout abort restarts the frame, so a coincident byte lands at address 0.
    assign timeout_s    = TIMEOUT_EN && (state_r == LOAD) && (byte_cnt_r != '0)
                          && (idle_cnt_r == TIMEOUT_LAST);
    assign overrun_s    = rx_rdy && (state_r != LOAD);
    assign wr_addr_s    = timeout_s ? '0 : byte_cnt_r;
    assign frame_done_s = (state_r == LOAD) && rx_rdy && (wr_addr_s == LAST_ADDR);
    // tx_start_r is high exactly in the first TX_WAIT cycle, masking a stale tx_rdy.
    assign tx_done_s    = (state_r == TX_WAIT) && tx_rdy && !tx_start_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD:    if (frame_done_s) state_nxt_s = START;   else state_nxt_s = LOAD;
            START:   state_nxt_s = RUN;
            RUN:     if (nn_done)      state_nxt_s = SEND;    else state_nxt_s = RUN;
            SEND:    if (tx_rdy)       state_nxt_s = TX_WAIT; else state_nxt_s = SEND;
            TX_WAIT: if (tx_done_s)    state_nxt_s = LOAD;    else state_nxt_s = TX_WAIT;
            default: state_nxt_s = LOAD;
        endcase
    end

    // Next values of the registered outputs and frame counters
    always_comb begin
        ram_we_nxt_s    = 1'b0;
        ram_waddr_nxt_s = ram_waddr_r;
        ram_wdata_nxt_s = ram_wdata_r;
        nn_start_nxt_s  = 1'b0;
        tx_start_nxt_s  = 1'b0;
        tx_data_nxt_s   = tx_data_r;
        result_nxt_s    = result_r;
        busy_nxt_s      = busy_r;
        err_nxt_s       = err_r | {timeout_s, overrun_s};
        byte_cnt_nxt_s  = byte_cnt_r;
        idle_cnt_nxt_s  = idle_cnt_r;
        case (state_r)
            LOAD: begin
                if (rx_rdy) begin
                    ram_we_nxt_s    = 1'b1;
                    ram_waddr_nxt_s = wr_addr_s;
                    ram_wdata_nxt_s = rx_data;
                    busy_nxt_s      = 1'b1;
                    idle_cnt_nxt_s  = '0;
                    if (frame_done_s) begin
                        byte_cnt_nxt_s = '0;
                    end else begin
                        byte_cnt_nxt_s = wr_addr_s + ADDR_WIDTH'(1);
                    end
                end else if (timeout_s) begin
                    byte_cnt_nxt_s = '0;
                    idle_cnt_nxt_s = '0;
                    busy_nxt_s     = 1'b0;
                end else if (byte_cnt_r != '0) begin
                    idle_cnt_nxt_s = idle_cnt_r + CNT_WIDTH'(1);
                end else begin
                    idle_cnt_nxt_s = '0;
                end
            end
            START: begin
                nn_start_nxt_s = 1'b1;
            end
            RUN: begin
                if (nn_done) begin
                    result_nxt_s = nn_digit;
                end else begin
                    result_nxt_s = result_r;
                end
            end
            SEND: begin
                if (tx_rdy) begin
                    tx_start_nxt_s = 1'b1;
                    tx_data_nxt_s  = {4'h0, result_r};
                end else begin
                    tx_start_nxt_s = 1'b0;
                end
            end
            TX_WAIT: begin
                if (tx_done_s) begin
                    busy_nxt_s = 1'b0;
                end else begin
                    busy_nxt_s = busy_r;
                end
            end
            default: begin
                byte_cnt_nxt_s = '0;
                idle_cnt_nxt_s = '0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we_r    <= 1'b0;
            ram_waddr_r <= '0;
            ram_wdata_r <= 8'h00;
            nn_start_r  <= 1'b0;
            tx_start_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            result_r    <= 4'h0;
            busy_r      <= 1'b0;
            err_r       <= 2'b00;
            byte_cnt_r  <= '0;
            idle_cnt_r  <= '0;
        end else begin
            ram_we_r    <= ram_we_nxt_s;
            ram_waddr_r <= ram_waddr_nxt_s;
            ram_wdata_r <= ram_wdata_nxt_s;
            nn_start_r  <= nn_start_nxt_s;
            tx_start_r  <= tx_start_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            result_r    <= result_nxt_s;
            busy_r      <= busy_nxt_s;
            err_r       <= err_nxt_s;
            byte_cnt_r  <= byte_cnt_nxt_s;
            idle_cnt_r  <= idle_cnt_nxt_s;
        end
    end

    assign ram_we    = ram_we_r;
    assign ram_waddr = ram_waddr_r;
    assign ram_wdata = ram_wdata_r;
    assign nn_start  = nn_start_r;
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign result    = result_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Directed self-checking bench for snn_frame_ctrl (timeout shortened to 100 cycles).
module tb_snn_frame_ctrl;

    localparam int NB = 98;
    localparam int AW = 7;
    localparam int TO = 100;
    localparam int CW = 20;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          rx_rdy   = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          nn_done  = 1'b0;
    logic [3:0]    nn_digit = 4'h0;
    logic          tx_rdy   = 1'b1;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic          nn_start;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [3:0]    result;
    logic          busy;
    logic [1:0]    err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_strobe_cyc = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [7:0]    wr_data_q[$];
    int wr_cyc_last = 0;
    int ns_total = 0;
    int ns_cyc = 0;
    int ts_total = 0;
    int ts_cyc = 0;

    snn_frame_ctrl #(
        .NUM_BYTES(NB), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .nn_start(nn_start), .nn_done(nn_done), .nn_digit(nn_digit),
        .tx_rdy(tx_rdy), .tx_start(tx_start), .tx_data(tx_data),
        .result(result), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every RAM write and pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_we) begin
            wr_addr_q.push_back(ram_waddr);
            wr_data_q.push_back(ram_wdata);
            wr_cyc_last = cyc;
        end
        if (nn_start) begin
            ns_total = ns_total + 1;
            ns_cyc   = cyc;
        end
        if (tx_start) begin
            ts_total = ts_total + 1;
            ts_cyc   = cyc;
        end
    end

    function automatic int count_bad(input int wb, input int base, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (wb + i >= wr_addr_q.size()) bad++;
            else if (wr_addr_q[wb+i] !== AW'(i) || wr_data_q[wb+i] !== 8'(base + i)) bad++;
        end
        return bad;
    endfunction

    task automatic feed_frame(input int n, input int base, input int gap, output int busy_lows);
        busy_lows = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_rdy = 1'b1;
            rx_data = 8'(base + i);
            last_strobe_cyc = cyc;
            @(posedge clk); #1;
            rx_rdy = 1'b0;
            @(negedge clk);
            if (!busy) busy_lows++;
            repeat (gap - 1) @(posedge clk);
        end
    endtask

    task automatic finish_inference(input logic [3:0] d, output bit ok);
        int n = 0;
        tx_rdy = 1'b1;
        @(posedge clk); #1;
        nn_done = 1'b1; nn_digit = d;
        @(posedge clk); #1;
        nn_done = 1'b0; nn_digit = 4'h0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ram_we !== 1'b0)    begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
        checks++; if (ram_waddr !== 7'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", ram_waddr); end
        checks++; if (nn_start !== 1'b0)  begin errors++; $display("FAIL reset_nn_start got %b exp 0", nn_start); end
        checks++; if (tx_start !== 1'b0)  begin errors++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        checks++; if (result !== 4'h0)    begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 2'b00)      begin errors++; $display("FAIL reset_err got %b exp 00", err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_frame_load();
        int wb = wr_addr_q.size();
        int nb = ns_total;
        int bl;
        feed_frame(NB, 0, 3, bl);
        repeat (4) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== NB) begin errors++; $display("FAIL load_count got %0d exp %0d", wr_addr_q.size() - wb, NB); end
        checks++; if (count_bad(wb, 0, NB) !== 0) begin errors++; $display("FAIL load_data bad entries %0d exp 0", count_bad(wb, 0, NB)); end
        checks++; if (wr_cyc_last !== last_strobe_cyc + 1) begin errors++; $display("FAIL load_we_latency got %0d exp %0d", wr_cyc_last, last_strobe_cyc + 1); end
        checks++; if (ns_total - nb !== 1) begin errors++; $display("FAIL load_nn_start_count got %0d exp 1", ns_total - nb); end
        checks++; if (ns_cyc !== last_strobe_cyc + 2) begin errors++; $display("FAIL load_nn_start_latency got %0d exp %0d", ns_cyc, last_strobe_cyc + 2); end
        checks++; if (bl !== 0) begin errors++; $display("FAIL load_busy_low got %0d exp 0", bl); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_run got %b exp 1", busy); end
    endtask

    task automatic test_result_tx();
        int tb0 = ts_total;
        tx_rdy = 1'b1;
        @(posedge clk); #1;
        nn_done = 1'b1; nn_digit = 4'd7;
        @(posedge clk); #1;
        nn_done = 1'b0; nn_digit = 4'd0;
        @(negedge clk);
        checks++; if (result !== 4'd7) begin errors++; $display("FAIL tx_result got %0d exp 7", result); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_start_early got %b exp 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL tx_start got %b exp 1", tx_start); end
        checks++; if (tx_data !== 8'h07) begin errors++; $display("FAIL tx_data got %h exp 07", tx_data); end
        tx_rdy = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tx_busy_wait got %b exp 1", busy); end
        checks++; if (tx_data !== 8'h07) begin errors++; $display("FAIL tx_data_hold got %h exp 07", tx_data); end
        tx_rdy = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tx_busy_done got %b exp 0", busy); end
        checks++; if (ts_total - tb0 !== 1) begin errors++; $display("FAIL tx_start_count got %0d exp 1", ts_total - tb0); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL tx_err got %b exp 00", err); end
    endtask

    task automatic test_tx_backpressure();
        int nb = ns_total;
        int tb0;
        int rise;
        int bl;
        tx_rdy = 1'b0;
        feed_frame(NB, 16, 1, bl);
        repeat (4) @(negedge clk);
        checks++; if (ns_total - nb !== 1) begin errors++; $display("FAIL bp_nn_start got %0d exp 1", ns_total - nb); end
        tb0 = ts_total;
        @(posedge clk); #1;
        nn_done = 1'b1; nn_digit = 4'hA;
        @(posedge clk); #1;
        nn_done = 1'b0; nn_digit = 4'h0;
        repeat (50) @(negedge clk);
        checks++; if (ts_total - tb0 !== 0) begin errors++; $display("FAIL bp_no_tx got %0d exp 0", ts_total - tb0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b exp 1", busy); end
        @(posedge clk); #1;
        tx_rdy = 1'b1;
        rise = cyc;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL bp_tx_early got %b exp 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL bp_tx_start got %b exp 1", tx_start); end
        checks++; if (tx_data !== 8'h0A) begin errors++; $display("FAIL bp_tx_data got %h exp 0a", tx_data); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_first_wait_ignored got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_done got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (ts_total - tb0 !== 1) begin errors++; $display("FAIL bp_tx_count got %0d exp 1", ts_total - tb0); end
        checks++; if (ts_cyc !== rise + 1) begin errors++; $display("FAIL bp_tx_latency got %0d exp %0d", ts_cyc, rise + 1); end
    endtask

    task automatic test_timeout();
        int s;
        int wb;
        int nb;
        int bl;
        bit ok;
        feed_frame(10, 8'h40, 1, bl);
        s = last_strobe_cyc;
        while (cyc < s + TO) @(negedge clk);
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL to_early_err got %b exp 00", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_early_busy got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL to_err got %b exp 10", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b exp 0", busy); end
        wb = wr_addr_q.size();
        nb = ns_total;
        feed_frame(NB, 8'h80, 1, bl);
        repeat (4) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== NB) begin errors++; $display("FAIL to_reload_count got %0d exp %0d", wr_addr_q.size() - wb, NB); end
        checks++; if (count_bad(wb, 8'h80, NB) !== 0) begin errors++; $display("FAIL to_reload_data bad entries %0d exp 0", count_bad(wb, 8'h80, NB)); end
        checks++; if (ns_total - nb !== 1) begin errors++; $display("FAIL to_nn_start got %0d exp 1", ns_total - nb); end
        finish_inference(4'd3, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_finish busy still %b exp 0", busy); end
        checks++; if (result !== 4'd3) begin errors++; $display("FAIL to_result got %0d exp 3", result); end
    endtask

    task automatic test_overrun();
        int wb;
        int nb;
        int bl;
        bit ok;
        feed_frame(NB, 8'hC0, 1, bl);
        repeat (4) @(negedge clk);
        wb = wr_addr_q.size();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rx_rdy = 1'b1; rx_data = 8'hEE;
            @(posedge clk); #1;
            rx_rdy = 1'b0;
        end
        repeat (2) @(negedge clk);
        checks++; if (wr_addr_q.size() !== wb) begin errors++; $display("FAIL ovr_no_write got %0d exp %0d", wr_addr_q.size(), wb); end
        checks++; if (err !== 2'b11) begin errors++; $display("FAIL ovr_err got %b exp 11", err); end
        finish_inference(4'd5, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovr_finish busy still %b exp 0", busy); end
        wb = wr_addr_q.size();
        nb = ns_total;
        feed_frame(NB, 8'h33, 1, bl);
        repeat (4) @(negedge clk);
        checks++; if (count_bad(wb, 8'h33, NB) !== 0) begin errors++; $display("FAIL ovr_next_frame bad entries %0d exp 0", count_bad(wb, 8'h33, NB)); end
        checks++; if (ns_total - nb !== 1) begin errors++; $display("FAIL ovr_nn_start got %0d exp 1", ns_total - nb); end
        finish_inference(4'd9, ok);
        checks++; if (tx_data !== 8'h09) begin errors++; $display("FAIL ovr_tx_data got %h exp 09", tx_data); end
    endtask

    task automatic test_reset_mid_frame();
        int wb;
        int nb;
        int tb0;
        int bl;
        bit ok;
        feed_frame(50, 8'h11, 1, bl);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL rst_mid_err got %b exp 00", err); end
        checks++; if (result !== 4'h0) begin errors++; $display("FAIL rst_mid_result got %h exp 0", result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        nb = ns_total;
        tb0 = ts_total;
        repeat (10) @(negedge clk);
        checks++; if (ns_total - nb !== 0 || ts_total - tb0 !== 0) begin errors++; $display("FAIL rst_mid_spurious nn %0d tx %0d exp 0 0", ns_total - nb, ts_total - tb0); end
        wb = wr_addr_q.size();
        feed_frame(NB, 8'h55, 1, bl);
        repeat (4) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== NB) begin errors++; $display("FAIL rst_mid_count got %0d exp %0d", wr_addr_q.size() - wb, NB); end
        checks++; if (count_bad(wb, 8'h55, NB) !== 0) begin errors++; $display("FAIL rst_mid_data bad entries %0d exp 0", count_bad(wb, 8'h55, NB)); end
        checks++; if (ns_total - nb !== 1) begin errors++; $display("FAIL rst_mid_nn_start got %0d exp 1", ns_total - nb); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL rst_mid_err_after got %b exp 00", err); end
        finish_inference(4'd2, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_mid_finish busy still %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_frame_load();
        test_result_tx();
        test_tx_backpressure();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_frame_ctrl.md
Name: snn_frame_ctrl

Overview:
Top-level sequencer for the SNN core.
- Collects one image frame of NUM_BYTES bytes from the UART receiver and writes them into the input RAM.
- Starts the network, waits for its classification, and returns the result byte through the UART transmitter.
- Sits between uart_rx/uart_tx and the SNN core inside snn; replaces any ad-hoc glue logic.

Parameters:
NUM_BYTES, 98, bytes per frame (784 packed input pixels)
ADDR_WIDTH, 7, input RAM address width; must satisfy 2**ADDR_WIDTH >= NUM_BYTES
TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of a partial frame before abort; 0 disables the timeout
CNT_WIDTH, 20, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_rdy  in  1  one-cycle strobe from uart_rx: rx_data valid
rx_data  in  8  received byte
ram_we  out  1  input RAM write enable
ram_waddr  out  ADDR_WIDTH  input RAM write address
ram_wdata  out  8  input RAM write data
nn_start  out  1  one-cycle pulse starting SNN inference
nn_done  in  1  one-cycle pulse from SNN: classification valid
nn_digit  in  4  classified digit, valid with nn_done
tx_rdy  in  1  uart_tx idle/ready
tx_start  out  1  one-cycle pulse to uart_tx
tx_data  out  8  byte to transmit
result  out  4  last classified digit (drives led)
busy  out  1  high from first byte of a frame until the result transmission completes
err  out  2  sticky: [0] overrun (byte dropped), [1] frame timeout

Behaviour:
- Reset: all outputs 0, byte_cnt 0, idle counter 0, state LOAD. Async assert, sync deassert expected upstream.
- All outputs are registered.
- States: LOAD, START, RUN, SEND, TX_WAIT.
- LOAD:
  - On rx_rdy: next cycle ram_we=1, ram_waddr=byte_cnt, ram_wdata=rx_data; byte_cnt increments; busy=1.
  - When the write at address NUM_BYTES-1 is issued: byte_cnt clears to 0, go to START.
- Timeout in LOAD:
  - Idle counter runs only while byte_cnt>0 and clears on each rx_rdy.
  - Reaching TIMEOUT_CYCLES: byte_cnt->0, busy->0, err[1]->1, stay in LOAD.
  - TIMEOUT_CYCLES=0: timeout never fires.
- START: nn_start=1 for exactly one cycle, then RUN. Latency: last rx_rdy at cycle T -> ram_we at T+1 -> nn_start at T+2.
- RUN:
  - Wait for nn_done; on it, latch result<=nn_digit and go to SEND.
  - nn_done seen in any other state is ignored.
- SEND:
  - When tx_rdy=1: tx_start=1 for one cycle, tx_data={4'h0, result}, go to TX_WAIT.
  - tx_data holds its value until the next send.
- TX_WAIT:
  - tx_rdy is ignored in the first cycle after tx_start.
  - Afterwards, wait for tx_rdy=1, then busy->0 and return to LOAD.
- Overrun:
  - rx_rdy in START/RUN/SEND/TX_WAIT drops the byte and sets err[0]=1; no RAM write occurs.
  - rx_rdy in the same cycle as a timeout abort is accepted as byte 0 of a new frame; err[1] is still set.
- err clears only on reset. result holds until the next nn_done.
- Reset mid-frame or mid-inference returns to LOAD with byte_cnt=0; no nn_start or tx_start is emitted afterwards.
- byte_cnt never exceeds NUM_BYTES-1; no address wrap.

Test Plan:
1. Reset, feed 98 rx_rdy strobes with bytes 0x00..0x61 (gaps of 3 cycles) -> RAM writes at addresses 0..97 with matching data; single nn_start exactly 2 cycles after the 98th strobe; busy=1 throughout.
2. After test 1, pulse nn_done with nn_digit=7 while tx_rdy=1 -> result=7, tx_start next cycle with tx_data=0x07; after tx_rdy drops then rises, busy=0 and state is LOAD.
3. Hold tx_rdy=0 for 50 cycles when nn_done arrives -> tx_start delayed until the cycle after tx_rdy rises; exactly one tx_start.
4. TIMEOUT_CYCLES=100: send 10 bytes, then idle 100 cycles -> err[1]=1, busy=0; a following full 98-byte frame writes from address 0 and triggers nn_start.
5. Send 3 extra rx_rdy strobes during RUN -> no ram_we, err[0]=1, byte_cnt still 0; next frame loads normally.
6. Assert rst_n=0 after 50 bytes, release, send 98 bytes -> writes restart at address 0; exactly one nn_start; err=0.
